// File: rtl/sensor_ctrl.sv
// Sensor frame capture: enables the sensor, stores words into a local buffer, interrupts when full.
// Optional: define SENSOR_CTRL_HALF_IRQ_EN for a one-cycle interrupt pulse at half frame.
module sensor_ctrl #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [AW:0]       sctrl_addr,
  output logic [DATA_W-1:0] sctrl_out,
  output logic [AW:0]       sctrl_count,
  output logic              sctrl_interrupt,
  output logic              sensor_en,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_LAST  = (AW+1)'(DEPTH - 1);
`ifdef SENSOR_CTRL_HALF_IRQ_EN
  localparam logic [AW:0]   CNT_HALF1 = (AW+1)'(DEPTH / 2 - 1);
`endif

  state_t              state, state_d;
  logic [AW-1:0]       wr_ptr, wr_ptr_d;
  logic [AW:0]         count_d;
  logic                wr_en;
  logic                sensor_en_d;
  logic                irq_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  // State, pointer and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      sctrl_count     <= '0;
      sensor_en       <= 1'b0;
      sctrl_interrupt <= 1'b0;
    end else begin
      state           <= state_d;
      wr_ptr          <= wr_ptr_d;
      sctrl_count     <= count_d;
      sensor_en       <= sensor_en_d;
      sctrl_interrupt <= irq_d;
    end
  end

  // Next-state, capture and output decode; clear overrides everything, including a coincident write
  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    count_d  = sctrl_count;
    wr_en    = (state == FILL) && sensor_en && sensor_ready && !sctrl_clear;

    if (sctrl_clear) begin
      state_d  = sctrl_en ? FILL : IDLE;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sctrl_en) state_d = FILL;
        end
        FILL: begin
          if (wr_en) begin
            wr_ptr_d = wr_ptr + PTR_ONE;
            count_d  = sctrl_count + CNT_ONE;
            if (sctrl_count == CNT_LAST) state_d = FULL;
            else if (!sctrl_en)          state_d = IDLE;
          end else if (!sctrl_en) begin
            state_d = IDLE;
          end
        end
        FULL: begin
          state_d = FULL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // sensor_en rises one cycle after FILL is entered but falls together with leaving FILL
    sensor_en_d = (state == FILL) && (state_d == FILL);
    irq_d       = (state_d == FULL);
`ifdef SENSOR_CTRL_HALF_IRQ_EN
    if (wr_en && (sctrl_count == CNT_HALF1)) irq_d = 1'b1;
`endif
  end

  // Frame buffer storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sensor_out;
  end

  // Synchronous read port; out-of-range addresses read as zero, same-cycle write returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sctrl_out <= '0;
    else        sctrl_out <= sctrl_addr[AW] ? '0 : mem[sctrl_addr[AW-1:0]];
  end

endmodule
